// File: rtl/ahb_pkg.sv
// Shared AHB-Lite definitions: transfer/response encodings, HSIZE codes and the
// responder state enum used by ahb_sram_slave and the VIP agents.
package ahb_pkg;

  typedef enum logic [1:0] {
    HtransIdle   = 2'b00,
    HtransBusy   = 2'b01,
    HtransNonseq = 2'b10,
    HtransSeq    = 2'b11
  } htrans_e;

  typedef enum logic [1:0] {
    HrespOkay  = 2'b00,
    HrespError = 2'b01
  } hresp_e;

  localparam logic [2:0] HsizeByte  = 3'd0;
  localparam logic [2:0] HsizeHalf  = 3'd1;
  localparam logic [2:0] HsizeWord  = 3'd2;
  localparam logic [2:0] HsizeDword = 3'd3;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StWait = 3'd1,
    StDone = 3'd2,
    StErr1 = 3'd3,
    StErr2 = 3'd4
  } ahb_slv_state_e;

endpackage

// File: rtl/ahb_sram_bytemem.sv
// Word-organised SRAM with per-byte write strobes and an asynchronous read port.
// Contents are deliberately not reset.
module ahb_sram_bytemem #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MEM_BYTES = 4096
) (
  input  logic                                          clk_i,
  input  logic                                          we_i,
  input  logic [$clog2(MEM_BYTES/(DATA_W/8))-1:0]       waddr_i,
  input  logic [DATA_W/8-1:0]                           strb_i,
  input  logic [DATA_W-1:0]                             wdata_i,
  input  logic [$clog2(MEM_BYTES/(DATA_W/8))-1:0]       raddr_i,
  output logic [DATA_W-1:0]                             rdata_o
);

  localparam int unsigned Bytes = DATA_W / 8;
  localparam int unsigned Words = MEM_BYTES / Bytes;

  logic [DATA_W-1:0] mem_q [Words];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int i = 0; i < Bytes; i++) begin
        if (strb_i[i]) mem_q[waddr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM responder: address/data-phase pipeline, programmable wait states
// and a two-cycle ERROR response for illegal transfers.
module ahb_sram_slave
  import ahb_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned MEM_BYTES   = 4096,
  parameter int unsigned WAIT_STATES = 0,
  parameter int unsigned HRESP_W     = 2
) (
  input  logic                HCLK,
  input  logic                HRESETn,
  input  logic                HSEL,
  input  logic [ADDR_W-1:0]   HADDR,
  input  logic [1:0]          HTRANS,
  input  logic                HWRITE,
  input  logic [2:0]          HSIZE,
  input  logic [2:0]          HBURST,
  input  logic [3:0]          HPROT,
  input  logic [DATA_W-1:0]   HWDATA,
  input  logic                HREADY,
  output logic                HREADYOUT,
  output logic [HRESP_W-1:0]  HRESP,
  output logic [DATA_W-1:0]   HRDATA
);

  localparam int unsigned Bytes   = DATA_W / 8;
  localparam int unsigned LaneW   = $clog2(Bytes);
  localparam int unsigned MemAW   = $clog2(MEM_BYTES);
  localparam int unsigned WordAW  = MemAW - LaneW;
  localparam logic [3:0]  WaitMax = 4'(WAIT_STATES);

  ahb_slv_state_e state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [MemAW-1:0] addr_q, addr_d;
  logic             write_q, write_d;
  logic [2:0]       size_q, size_d;

  logic              can_accept, accept, misaligned, illegal;
  logic [ADDR_W-1:0] align_mask;
  logic [Bytes-1:0]  strb;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  always_comb begin
    // Only states that drive HREADYOUT high may take a new address phase.
    can_accept = (state_q == StIdle) || (state_q == StDone) || (state_q == StErr2);
    accept     = can_accept && HSEL && HREADY && HTRANS[1];
    align_mask = (ADDR_W'(1) << HSIZE) - ADDR_W'(1);
    misaligned = |(HADDR & align_mask);
    illegal    = (32'(HSIZE) > LaneW) || misaligned || (HADDR >= ADDR_W'(MEM_BYTES));
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    addr_d  = addr_q;
    write_d = write_q;
    size_d  = size_q;
    unique case (state_q)
      StWait: begin
        if (cnt_q == WaitMax) begin
          state_d = StDone;
        end else begin
          state_d = StWait;
          cnt_d   = cnt_q + 4'd1;
        end
      end
      StErr1: state_d = StErr2;
      default: begin
        state_d = StIdle;
        if (accept) begin
          addr_d  = HADDR[MemAW-1:0];
          write_d = HWRITE && !illegal;
          size_d  = HSIZE;
          if (illegal) begin
            state_d = StErr1;
          end else if (WAIT_STATES > 0) begin
            state_d = StWait;
            cnt_d   = 4'd1;
          end else begin
            state_d = StDone;
          end
        end
      end
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      addr_q  <= '0;
      write_q <= 1'b0;
      size_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      size_q  <= size_d;
    end
  end

  // A lane is enabled when it sits in the same naturally aligned chunk as the address.
  always_comb begin
    strb = '0;
    for (int unsigned i = 0; i < Bytes; i++) begin
      strb[i] = ((i >> size_q) == (32'(addr_q[LaneW-1:0]) >> size_q));
    end
  end

  assign mem_we = (state_q == StDone) && write_q;

  ahb_sram_bytemem #(
    .DATA_W    (DATA_W),
    .MEM_BYTES (MEM_BYTES)
  ) u_mem (
    .clk_i   (HCLK),
    .we_i    (mem_we),
    .waddr_i (addr_q[MemAW-1:LaneW]),
    .strb_i  (strb),
    .wdata_i (HWDATA),
    .raddr_i (addr_q[MemAW-1:LaneW]),
    .rdata_o (mem_rdata)
  );

  assign HREADYOUT = !((state_q == StWait) || (state_q == StErr1));
  assign HRESP     = ((state_q == StErr1) || (state_q == StErr2)) ? HRESP_W'(HrespError)
                                                                  : HRESP_W'(HrespOkay);
  assign HRDATA    = ((state_q == StDone) && !write_q) ? mem_rdata : '0;

  logic unused_ahb;
  assign unused_ahb = ^{HBURST, HPROT, HTRANS[0], WordAW};

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Directed bench for ahb_sram_slave: three instances (0, 2 and 3 wait states)
// share one AHB bus; per-cycle vector tables plus hand-written reset sequences.
module tb_ahb_sram_slave;

  localparam logic [1:0] TI = 2'b00;
  localparam logic [1:0] TB = 2'b01;
  localparam logic [1:0] TN = 2'b10;
  localparam logic [1:0] TS = 2'b11;

  typedef struct packed {
    logic [1:0]  sel;
    logic        hsel;
    logic [1:0]  trans;
    logic        wr;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rdy;
    logic [1:0]  resp;
    logic [31:0] rdata;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  sel = 2'd0;
  logic        hsel = 1'b0;
  logic [31:0] haddr = '0;
  logic [1:0]  htrans = TI;
  logic        hwrite = 1'b0;
  logic [2:0]  hsize = 3'd2;
  logic [2:0]  hburst = 3'd0;
  logic [3:0]  hprot = 4'd3;
  logic [31:0] hwdata = '0;
  logic        hready;
  logic [2:0]  hsel_v;
  logic [2:0]  hreadyout;
  logic [2:0][1:0]  hresp;
  logic [2:0][31:0] hrdata;

  int checks = 0;
  int errors = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  assign hsel_v[0] = hsel && (sel == 2'd0);
  assign hsel_v[1] = hsel && (sel == 2'd1);
  assign hsel_v[2] = hsel && (sel == 2'd2);
  assign hready    = hreadyout[sel];

  ahb_sram_slave #(.WAIT_STATES(0)) u_ws0 (
    .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel_v[0]), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot), .HWDATA(hwdata),
    .HREADY(hready), .HREADYOUT(hreadyout[0]), .HRESP(hresp[0]), .HRDATA(hrdata[0])
  );

  ahb_sram_slave #(.WAIT_STATES(2)) u_ws2 (
    .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel_v[1]), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot), .HWDATA(hwdata),
    .HREADY(hready), .HREADYOUT(hreadyout[1]), .HRESP(hresp[1]), .HRDATA(hrdata[1])
  );

  ahb_sram_slave #(.WAIT_STATES(3)) u_ws3 (
    .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel_v[2]), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot), .HWDATA(hwdata),
    .HREADY(hready), .HREADYOUT(hreadyout[2]), .HRESP(hresp[2]), .HRDATA(hrdata[2])
  );

  function automatic void add(input logic [1:0] s, input logic hs, input logic [1:0] t,
                              input logic w, input logic [2:0] sz, input logic [31:0] a,
                              input logic [31:0] d, input logic r, input logic [1:0] rs,
                              input logic [31:0] rd);
    vec_t v;
    v.sel = s; v.hsel = hs; v.trans = t; v.wr = w; v.size = sz; v.addr = a;
    v.wdata = d; v.rdy = r; v.resp = rs; v.rdata = rd;
    vecs.push_back(v);
  endfunction

  task automatic drive(input logic [1:0] s, input logic hs, input logic [1:0] t,
                       input logic w, input logic [2:0] sz, input logic [31:0] a,
                       input logic [31:0] d);
    sel = s; hsel = hs; htrans = t; hwrite = w; hsize = sz; haddr = a; hwdata = d;
  endtask

  task automatic cyc(input logic [1:0] s, input logic [1:0] t, input logic w,
                     input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    drive(s, 1'b1, t, w, 3'd2, a, d);
    #1;
  endtask

  task automatic check(input string name, input int idx, input logic exp_rdy,
                       input logic [1:0] exp_resp, input logic [31:0] exp_rdata);
    checks++;
    if (hreadyout[idx] !== exp_rdy) begin
      errors++;
      $display("FAIL %s dut%0d HREADYOUT got %b want %b", name, idx, hreadyout[idx], exp_rdy);
    end
    checks++;
    if (hresp[idx] !== exp_resp) begin
      errors++;
      $display("FAIL %s dut%0d HRESP got %b want %b", name, idx, hresp[idx], exp_resp);
    end
    checks++;
    if (hrdata[idx] !== exp_rdata) begin
      errors++;
      $display("FAIL %s dut%0d HRDATA got %h want %h", name, idx, hrdata[idx], exp_rdata);
    end
  endtask

  initial begin
    // 0 wait states: pipelined write/read, byte and halfword lanes, errors, BUSY, HSEL low
    add(0, 1, TN, 1, 2, 32'h10,   32'h0,        1, 0, 32'h0);
    add(0, 1, TN, 0, 2, 32'h10,   32'hDEADBEEF, 1, 0, 32'h0);
    add(0, 1, TN, 1, 1, 32'h12,   32'h0,        1, 0, 32'hDEADBEEF);
    add(0, 1, TN, 0, 2, 32'h10,   32'h55660000, 1, 0, 32'h0);
    add(0, 1, TN, 1, 2, 32'h20,   32'h0,        1, 0, 32'h5566BEEF);
    add(0, 1, TN, 1, 0, 32'h21,   32'h11223344, 1, 0, 32'h0);
    add(0, 1, TN, 0, 2, 32'h20,   32'h0000AB00, 1, 0, 32'h0);
    add(0, 1, TI, 0, 2, 32'h0,    32'h0,        1, 0, 32'h1122AB44);
    add(0, 1, TN, 0, 2, 32'h1000, 32'h0,        1, 0, 32'h0);
    add(0, 1, TI, 0, 2, 32'h0,    32'h0,        0, 1, 32'h0);
    add(0, 1, TI, 0, 2, 32'h0,    32'h0,        1, 1, 32'h0);
    add(0, 1, TN, 1, 2, 32'h22,   32'h0,        1, 0, 32'h0);
    add(0, 1, TI, 0, 2, 32'h0,    32'hFFFFFFFF, 0, 1, 32'h0);
    add(0, 1, TN, 0, 2, 32'h20,   32'hFFFFFFFF, 1, 1, 32'h0);
    add(0, 1, TN, 0, 3, 32'h0,    32'h0,        1, 0, 32'h1122AB44);
    add(0, 1, TI, 0, 2, 32'h0,    32'h0,        0, 1, 32'h0);
    add(0, 1, TB, 0, 2, 32'h10,   32'h0,        1, 1, 32'h0);
    add(0, 0, TN, 0, 2, 32'h10,   32'h0,        1, 0, 32'h0);
    add(0, 1, TI, 0, 2, 32'h0,    32'h0,        1, 0, 32'h0);
    // 2 wait states: next address is only taken on the HREADY=1 cycle
    add(1, 1, TN, 1, 2, 32'h4,    32'h0,        1, 0, 32'h0);
    add(1, 1, TS, 1, 2, 32'h8,    32'hA5A50F0F, 0, 0, 32'h0);
    add(1, 1, TS, 1, 2, 32'h8,    32'hA5A50F0F, 0, 0, 32'h0);
    add(1, 1, TS, 1, 2, 32'h8,    32'hA5A50F0F, 1, 0, 32'h0);
    add(1, 1, TN, 0, 2, 32'h4,    32'h12345678, 0, 0, 32'h0);
    add(1, 1, TN, 0, 2, 32'h4,    32'h12345678, 0, 0, 32'h0);
    add(1, 1, TN, 0, 2, 32'h4,    32'h12345678, 1, 0, 32'h0);
    add(1, 1, TS, 0, 2, 32'h8,    32'h0,        0, 0, 32'h0);
    add(1, 1, TS, 0, 2, 32'h8,    32'h0,        0, 0, 32'h0);
    add(1, 1, TS, 0, 2, 32'h8,    32'h0,        1, 0, 32'hA5A50F0F);
    add(1, 1, TI, 0, 2, 32'h0,    32'h0,        0, 0, 32'h0);
    add(1, 1, TI, 0, 2, 32'h0,    32'h0,        0, 0, 32'h0);
    add(1, 1, TI, 0, 2, 32'h0,    32'h0,        1, 0, 32'h12345678);
    add(1, 1, TN, 0, 2, 32'h1000, 32'h0,        1, 0, 32'h0);
    add(1, 1, TI, 0, 2, 32'h0,    32'h0,        0, 1, 32'h0);
    add(1, 1, TI, 0, 2, 32'h0,    32'h0,        1, 1, 32'h0);
    add(1, 1, TI, 0, 2, 32'h0,    32'h0,        1, 0, 32'h0);

    // Reset held with random inputs: all instances stay ready/OKAY/zero
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      drive(2'($urandom_range(0, 2)), 1'($urandom), 2'($urandom), 1'($urandom),
            3'($urandom), $urandom, $urandom);
      #1;
      for (int k = 0; k < 3; k++) check($sformatf("reset%0d", c), k, 1'b1, 2'b00, 32'h0);
    end
    @(negedge clk);
    drive(0, 1'b0, TI, 1'b0, 3'd2, 32'h0, 32'h0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].sel, vecs[i].hsel, vecs[i].trans, vecs[i].wr, vecs[i].size,
            vecs[i].addr, vecs[i].wdata);
      #1;
      check($sformatf("vec%0d", i), int'(vecs[i].sel), vecs[i].rdy, vecs[i].resp,
            vecs[i].rdata);
    end

    // 3 wait states: reset in the 2nd wait cycle of a write discards it
    cyc(2, TN, 1'b1, 32'h30, 32'h0);           check("ws3_w0_addr", 2, 1, 0, 0);
    cyc(2, TI, 1'b0, 32'h0, 32'hCAFEF00D);     check("ws3_w0_wait1", 2, 0, 0, 0);
    cyc(2, TI, 1'b0, 32'h0, 32'hCAFEF00D);     check("ws3_w0_wait2", 2, 0, 0, 0);
    cyc(2, TI, 1'b0, 32'h0, 32'hCAFEF00D);     check("ws3_w0_wait3", 2, 0, 0, 0);
    cyc(2, TN, 1'b1, 32'h30, 32'hCAFEF00D);    check("ws3_w0_done", 2, 1, 0, 0);
    cyc(2, TI, 1'b0, 32'h0, 32'h0BADBEEF);     check("ws3_w1_wait1", 2, 0, 0, 0);
    cyc(2, TI, 1'b0, 32'h0, 32'h0BADBEEF);     check("ws3_w1_wait2", 2, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    check("ws3_async_rst", 2, 1, 0, 0);
    @(negedge clk);
    drive(2, 1'b0, TI, 1'b0, 3'd2, 32'h0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(2, TN, 1'b0, 32'h30, 32'h0);           check("ws3_r_addr", 2, 1, 0, 0);
    cyc(2, TI, 1'b0, 32'h0, 32'h0);            check("ws3_r_wait1", 2, 0, 0, 0);
    cyc(2, TI, 1'b0, 32'h0, 32'h0);            check("ws3_r_wait2", 2, 0, 0, 0);
    cyc(2, TI, 1'b0, 32'h0, 32'h0);            check("ws3_r_wait3", 2, 0, 0, 0);
    cyc(2, TI, 1'b0, 32'h0, 32'h0);            check("ws3_r_done", 2, 1, 0, 32'hCAFEF00D);
    cyc(2, TI, 1'b0, 32'h0, 32'h0);            check("ws3_r_idle", 2, 1, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
